// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: produces the tuning word for the downstream phase accumulator.
// It runs linear frequency sweeps from f_start to f_stop in steps of f_step.
// Each word is held for a programmable dwell. Three modes are supported:
// single-shot, sawtooth (repeating) and triangle (up/down).
module dds_sweep_ctrl #(
  parameter int FTW_W   = 16,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FTW_W-1:0]   f_start,
  input  logic [FTW_W-1:0]   f_stop,
  input  logic [FTW_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   ftw,
  output logic               ftw_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               dir_down
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [FTW_W-1:0]   ftw_reg, ftw_next;
  logic               ftw_valid_reg, ftw_valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               cfg_err_reg, cfg_err_next;
  logic               dir_down_reg, dir_down_next;
  logic [DWELL_W-1:0] counter_reg, counter_next;

  // Configuration captured at start; the live inputs are ignored while running.
  logic [1:0]         mode_reg, mode_next;
  logic [FTW_W-1:0]   f_start_reg, f_start_next;
  logic [FTW_W-1:0]   f_stop_reg, f_stop_next;
  logic [FTW_W-1:0]   f_step_reg, f_step_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;

  // Step arithmetic on the captured configuration.
  // The upward sum carries one extra bit so it cannot wrap past f_stop.
  // The downward step is compared against the remaining room so it cannot underflow.
  logic [FTW_W:0]     up_sum;
  logic [FTW_W-1:0]   up_word;
  logic [FTW_W-1:0]   down_room;
  logic [FTW_W-1:0]   down_word;
  logic [DWELL_W-1:0] dwell_eff;
  logic               cfg_bad;
  logic               expiry;

  assign up_sum    = {1'b0, ftw_reg} + {1'b0, f_step_reg};
  assign up_word   = (up_sum >= {1'b0, f_stop_reg}) ? f_stop_reg : up_sum[FTW_W-1:0];
  assign down_room = ftw_reg - f_start_reg;
  assign down_word = (f_step_reg >= down_room) ? f_start_reg : (ftw_reg - f_step_reg);
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign cfg_bad   = (f_step == '0) || (f_start > f_stop);
  assign expiry    = (counter_reg == DWELL_W'(1));

  assign ftw       = ftw_reg;
  assign ftw_valid = ftw_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign cfg_err   = cfg_err_reg;
  assign dir_down  = dir_down_reg;

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ftw_reg       <= '0;
      ftw_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
      dir_down_reg  <= 1'b0;
      counter_reg   <= '0;
      mode_reg      <= '0;
      f_start_reg   <= '0;
      f_stop_reg    <= '0;
      f_step_reg    <= '0;
      dwell_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ftw_reg       <= ftw_next;
      ftw_valid_reg <= ftw_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      cfg_err_reg   <= cfg_err_next;
      dir_down_reg  <= dir_down_next;
      counter_reg   <= counter_next;
      mode_reg      <= mode_next;
      f_start_reg   <= f_start_next;
      f_stop_reg    <= f_stop_next;
      f_step_reg    <= f_step_next;
      dwell_reg     <= dwell_next;
    end
  end

  // Next-state logic for starting a sweep, dwell counting and step/turnaround rules.
  always_comb begin
    state_next     = state_reg;
    ftw_next       = ftw_reg;
    ftw_valid_next = 1'b0;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    cfg_err_next   = 1'b0;
    dir_down_next  = dir_down_reg;
    counter_next   = counter_reg;
    mode_next      = mode_reg;
    f_start_next   = f_start_reg;
    f_stop_next    = f_stop_reg;
    f_step_next    = f_step_reg;
    dwell_next     = dwell_reg;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_bad) begin
            cfg_err_next = 1'b1;
          end else begin
            mode_next      = mode;
            f_start_next   = f_start;
            f_stop_next    = f_stop;
            f_step_next    = f_step;
            dwell_next     = dwell_eff;
            ftw_next       = f_start;
            ftw_valid_next = 1'b1;
            busy_next      = 1'b1;
            dir_down_next  = 1'b0;
            counter_next   = dwell_eff;
            state_next     = RUN;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else if (expiry) begin
          counter_next = dwell_reg;
          if (!dir_down_reg) begin
            if (ftw_reg != f_stop_reg) begin
              ftw_next       = up_word;
              ftw_valid_next = 1'b1;
            end else if (mode_reg == 2'd1) begin
              ftw_next       = f_start_reg;
              ftw_valid_next = 1'b1;
            end else if (mode_reg == 2'd2) begin
              dir_down_next  = 1'b1;
              ftw_next       = down_word;
              ftw_valid_next = 1'b1;
            end else begin
              // Modes 0 and 3: the single sweep ends with the word parked at f_stop.
              state_next = IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            if (ftw_reg != f_start_reg) begin
              ftw_next       = down_word;
              ftw_valid_next = 1'b1;
            end else begin
              dir_down_next  = 1'b0;
              ftw_next       = up_word;
              ftw_valid_next = 1'b1;
            end
          end
        end else begin
          counter_next = counter_reg - DWELL_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl.
// The stimulus pushes the expected output events (cycle, word, direction, kind)
// into a scoreboard queue. A monitor pops an entry and compares it whenever the
// DUT pulses ftw_valid, done or cfg_err.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_step;
  logic [23:0] dwell;
  logic [15:0] ftw;
  logic        ftw_valid;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        dir_down;

  dds_sweep_ctrl #(.FTW_W(16), .DWELL_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .ftw       (ftw),
    .ftw_valid (ftw_valid),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .dir_down  (dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count; an event seen at the negedge after posedge n has cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ftw;
    bit dir;
    bit is_done;
    bit is_err;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_ftw = 0;

  task automatic push(input int c, input int w, input bit d, input bit dn, input bit er);
    ev_t e;
    e.cyc = c; e.ftw = w; e.dir = d; e.is_done = dn; e.is_err = er;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: each output pulse is one transaction compared against the scoreboard head.
  ev_t m_e;
  always @(negedge clk) begin
    if (rst_n && (ftw_valid || done || cfg_err)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d ftw=%0d valid=%b done=%b cfg_err=%b busy=%b",
                 cyc, ftw, ftw_valid, done, cfg_err, busy);
      end else begin
        m_e = sb.pop_front();
        if (cyc != m_e.cyc || ftw_valid != !(m_e.is_done || m_e.is_err) ||
            done != m_e.is_done || cfg_err != m_e.is_err || int'(ftw) != m_e.ftw ||
            busy != !(m_e.is_done || m_e.is_err) || (!m_e.is_err && dir_down != m_e.dir)) begin
          errors++;
          $display("FAIL event actual: cyc=%0d ftw=%0d v=%b done=%b err=%b busy=%b dir=%b required: cyc=%0d ftw=%0d done=%b err=%b dir=%b",
                   cyc, ftw, ftw_valid, done, cfg_err, busy, dir_down,
                   m_e.cyc, m_e.ftw, m_e.is_done, m_e.is_err, m_e.dir);
        end else begin
          $display("txn cyc=%0d ftw=%0d valid=%b done=%b cfg_err=%b dir_down=%b",
                   cyc, ftw, ftw_valid, done, cfg_err, dir_down);
        end
      end
    end
  end

  task automatic rand_cfg();
    mode    = 2'($urandom_range(0, 3));
    f_start = 16'($urandom);
    f_stop  = 16'($urandom);
    f_step  = 16'($urandom);
    dwell   = 24'($urandom_range(0, 5));
  endtask

  // Runs one start with the given configuration.
  // stop_kind: 0 = let a single sweep finish; 1 = abort at cycle c0+lim; 2 = reset at c0+lim.
  task automatic run_sweep(input int m, input int fs, input int fp, input int st, input int dw,
                           input int stop_kind, input int lim_in);
    int  dd, w, rel, c0, lim, done_rel, end_c, start_end, last_w;
    bit  dirv;
    dd = (dw == 0) ? 1 : dw;
    lim = (stop_kind == 0) ? 32'h4000_0000 : lim_in;
    @(negedge clk);
    c0 = cyc;
    mode = 2'(m); f_start = 16'(fs); f_stop = 16'(fp); f_step = 16'(st); dwell = 24'(dw);
    start = 1'b1; abort = 1'b0;
    if (st == 0 || fs > fp) begin
      push(c0 + 1, exp_ftw, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("reject_busy", int'(busy), 0);
      return;
    end
    // Reference: walk the word sequence; each word lives dd cycles from its first appearance.
    w = fs; dirv = 1'b0; rel = 1; done_rel = 32'h4000_0000;
    push(c0 + 1, w, 1'b0, 1'b0, 1'b0);
    last_w = w;
    forever begin
      rel += dd;
      if (rel > lim) break;
      if (!dirv) begin
        if (w != fp) w = (w + st > fp) ? fp : w + st;
        else if (m == 1) w = fs;
        else if (m == 2) begin dirv = 1'b1; w = (w - st < fs) ? fs : w - st; end
        else begin
          push(c0 + rel, fp, 1'b0, 1'b1, 1'b0);
          done_rel = rel;
          break;
        end
      end else begin
        if (w != fs) w = (w - st < fs) ? fs : w - st;
        else begin dirv = 1'b0; w = (w + st > fp) ? fp : w + st; end
      end
      push(c0 + rel, w, dirv, 1'b0, 1'b0);
      last_w = w;
    end
    end_c = (stop_kind == 0) ? c0 + done_rel : c0 + lim;
    start_end = (c0 + done_rel < end_c) ? c0 + done_rel : end_c;
    @(negedge clk);
    start = 1'b0;
    // Scramble the live config and pulse start while running; neither may have an effect.
    while (cyc < end_c) begin
      rand_cfg();
      start = (cyc < start_end) && ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    if (stop_kind == 1) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_ftw_hold", int'(ftw), last_w);
      repeat (3) @(negedge clk);
      chk("abort_ftw_later", int'(ftw), last_w);
      exp_ftw = last_w;
    end else if (stop_kind == 2) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_ftw", int'(ftw), 0);
      chk("rst_async_busy", int'(busy), 0);
      chk("rst_async_dir", int'(dir_down), 0);
      repeat (2) @(negedge clk);
      chk("rst_hold_valid", int'(ftw_valid), 0);
      rst_n = 1'b1;
      exp_ftw = 0;
    end else begin
      @(negedge clk);
      chk("done_busy", int'(busy), 0);
      chk("done_ftw_hold", int'(ftw), fp);
      exp_ftw = fp;
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int m, fs, fp, st, dw, kind, lim, span;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    mode = '0; f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (3) @(negedge clk);
    chk("reset_ftw", int'(ftw), 0);
    chk("reset_valid", int'(ftw_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cfg_err", int'(cfg_err), 0);
    chk("reset_dir", int'(dir_down), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a triangle sweep, then a clean single sweep.
    run_sweep(2, 100, 900, 50, 3, 2, 20);
    run_sweep(0, 1000, 1321, 100, 4, 0, 0);
    // Triangle turnarounds at dwell 1.
    run_sweep(2, 10, 30, 10, 1, 1, 6);
    // Sawtooth at the top of the range: no wrap on the clamped step.
    run_sweep(1, 65000, 65535, 400, 2, 1, 8);
    // Rejected configurations.
    run_sweep(0, 100, 200, 0, 2, 0, 0);
    run_sweep(0, 500, 400, 5, 1, 0, 0);
    // start together with abort in idle does nothing.
    @(negedge clk);
    mode = 2'd0; f_start = 16'd1; f_stop = 16'd50; f_step = 16'd7; dwell = 24'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_ftw", int'(ftw), exp_ftw);
    // Abort exactly on the expiry edge that would load 1200.
    run_sweep(0, 1000, 1321, 100, 4, 1, 8);
    // Equal start/stop words.
    run_sweep(0, 777, 777, 3, 3, 0, 0);
    run_sweep(1, 777, 777, 3, 2, 1, 9);
    run_sweep(2, 777, 777, 3, 2, 1, 9);

    // Randomized configurations.
    for (int i = 0; i < 40; i++) begin
      m  = $urandom_range(0, 3);
      fs = $urandom_range(0, 65535);
      span = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(0, 65535 - fs);
      fp = fs + span;
      st = span / $urandom_range(1, 12) + $urandom_range(1, 40);
      if (st > 65535) st = 65535;
      dw = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) st = 0;
      if ($urandom_range(0, 9) == 0 && fs < fp) begin
        int t;
        t = fs; fs = fp; fp = t;
      end
      lim = $urandom_range(1, 60);
      if (m == 1 || m == 2) kind = ($urandom_range(0, 4) == 0) ? 2 : 1;
      else kind = $urandom_range(0, 2) == 0 ? 1 : 0;
      run_sweep(m, fs, fp, st, dw, kind, lim);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
